meas_window_acc: RTL and testbench

MEAS_WINDOW_ACC -- requirements
Module: meas_window_acc

---
 rtl/meas_window_acc_pkg.sv | 17 +
 rtl/meas_ch_acc.sv | 137 +++++++++++++
 rtl/meas_window_acc.sv | 145 ++++++++++++++
 tb/tb_meas_window_acc.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_window_acc_pkg.sv
// Shared definitions for the windowed measurement accumulator.
//   state_e  : control FSM state encoding (idle / accumulating / result load)
//   sat_max  : largest positive value of a signed two's-complement word,
//              used to saturate |x| and x^2 when x is the most negative code
package meas_window_acc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic [31:0] sat_max(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/meas_ch_acc.sv
// One channel of the windowed measurement datapath: saturated |dec_var|,
// dec_var^2 and err^2 terms, their window accumulators and the result
// registers that hold the window means.
// Optional feature macro: MEAS_PEAK_ERR_EN adds a running max |err| and
// output peak_err.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clr             : discard accumulated sums (new window)
//   add             : fold the current sample into the sums
//   load            : copy sums >> LOG2_WIN into the result registers
//   dec_var, err    : signed 1sX sample inputs for this channel
//   mean_abs        : mean |dec_var| of the last completed window
//   avg_pow         : mean dec_var^2 of the last completed window
//   acc_sq_err      : mean err^2 of the last completed window
//   peak_err        : max |err| of the last completed window (macro only)
module meas_ch_acc
    import meas_window_acc_pkg::*;
#(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned LOG2_WIN = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     add,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] dec_var,
    input  logic signed [DATA_W-1:0] err,
    output logic [DATA_W-1:0]        mean_abs,
    output logic [DATA_W-1:0]        avg_pow,
    output logic [DATA_W-1:0]        acc_sq_err
`ifdef MEAS_PEAK_ERR_EN
    ,
    output logic [DATA_W-1:0]        peak_err
`endif
);

    // Every term fits in DATA_W-1 bits, so N terms fit in DATA_W-1+LOG2_WIN bits.
    localparam int unsigned      AccW   = DATA_W - 1 + LOG2_WIN;
    localparam logic [DATA_W-1:0] SatMax = DATA_W'(sat_max(DATA_W));
    localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W - 1){1'b0}}};

    function automatic logic [DATA_W-2:0] abs_sat(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] mag;
        if (x == MinVal) begin
            mag = SatMax;
        end else if (x[DATA_W-1]) begin
            mag = -x;
        end else begin
            mag = x;
        end
        return mag[DATA_W-2:0];
    endfunction

    // Square in 1sX format; only the most negative input can reach bit DATA_W-1.
    function automatic logic [DATA_W-2:0] sq_sat(input logic signed [DATA_W-1:0] x);
        logic signed [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]          sq;
        prod = x * x;
        sq   = prod[2*DATA_W-2 -: DATA_W];
        if (x == MinVal) begin
            sq = SatMax;
        end
        return sq[DATA_W-2:0];
    endfunction

    function automatic logic [AccW-1:0] ext(input logic [DATA_W-2:0] v);
        return {{LOG2_WIN{1'b0}}, v};
    endfunction

    logic [DATA_W-2:0] abs_dec, sq_dec, sq_err;
    logic [AccW-1:0]   acc_abs_q, acc_abs_d;
    logic [AccW-1:0]   acc_pow_q, acc_pow_d;
    logic [AccW-1:0]   acc_err_q, acc_err_d;

    assign abs_dec = abs_sat(dec_var);
    assign sq_dec  = sq_sat(dec_var);
    assign sq_err  = sq_sat(err);

    always_comb begin
        acc_abs_d = clr ? '0 : acc_abs_q;
        acc_pow_d = clr ? '0 : acc_pow_q;
        acc_err_d = clr ? '0 : acc_err_q;
        if (add) begin
            acc_abs_d = acc_abs_d + ext(abs_dec);
            acc_pow_d = acc_pow_d + ext(sq_dec);
            acc_err_d = acc_err_d + ext(sq_err);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_abs_q  <= '0;
            acc_pow_q  <= '0;
            acc_err_q  <= '0;
            mean_abs   <= '0;
            avg_pow    <= '0;
            acc_sq_err <= '0;
        end else begin
            acc_abs_q <= acc_abs_d;
            acc_pow_q <= acc_pow_d;
            acc_err_q <= acc_err_d;
            if (load) begin
                mean_abs   <= {1'b0, acc_abs_q[AccW-1:LOG2_WIN]};
                avg_pow    <= {1'b0, acc_pow_q[AccW-1:LOG2_WIN]};
                acc_sq_err <= {1'b0, acc_err_q[AccW-1:LOG2_WIN]};
            end
        end
    end

`ifdef MEAS_PEAK_ERR_EN
    logic [DATA_W-2:0] abs_err;
    logic [DATA_W-2:0] pk_q, pk_d;

    assign abs_err = abs_sat(err);

    always_comb begin
        pk_d = clr ? '0 : pk_q;
        if (add && (abs_err > pk_d)) begin
            pk_d = abs_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pk_q     <= '0;
            peak_err <= '0;
        end else begin
            pk_q <= pk_d;
            if (load) begin
                peak_err <= {1'b0, pk_q};
            end
        end
    end
`endif

endmodule

// File: rtl/meas_window_acc.sv
// Windowed measurement accumulator: over windows of N = 2^LOG2_WIN symbols it
// reports per-channel mean |dec_var|, mean dec_var^2 and mean err^2.
// One shared FSM/counter drives NUM_CH meas_ch_acc datapath slices.
// Optional feature macro: MEAS_PEAK_ERR_EN adds output peak_err (max |err|).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clk_en          : symbol-rate sample enable
//   start, abort    : begin / stop a window
//   mode_cont       : restart windows back-to-back
//   dec_var, err    : packed signed samples, channel 0 in the LSBs
//   mean_abs, avg_pow, acc_sq_err : packed per-channel window results
//   busy            : FSM not idle
//   done            : one-cycle pulse, coincident with new results
//   peak_err        : packed per-channel max |err| (macro only)
module meas_window_acc
    import meas_window_acc_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned LOG2_WIN = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mode_cont,
    input  logic [NUM_CH*DATA_W-1:0] dec_var,
    input  logic [NUM_CH*DATA_W-1:0] err,
    output logic [NUM_CH*DATA_W-1:0] mean_abs,
    output logic [NUM_CH*DATA_W-1:0] avg_pow,
    output logic [NUM_CH*DATA_W-1:0] acc_sq_err,
    output logic                     busy,
    output logic                     done
`ifdef MEAS_PEAK_ERR_EN
    ,
    output logic [NUM_CH*DATA_W-1:0] peak_err
`endif
);

    state_e              state_q, state_d;
    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic                clr, add, load;
    logic                done_q;
    logic                last;

    // Count wraps to zero on the N-th sample, so all-ones marks the final one.
    assign last = (cnt_q == {LOG2_WIN{1'b1}});
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= load;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) state_d = StAcc;
            end
            StAcc: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (clk_en && last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (mode_cont) begin
                    state_d = StAcc;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        clr   = 1'b0;
        add   = 1'b0;
        load  = 1'b0;
        cnt_d = cnt_q;
        busy  = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    clr   = 1'b1;
                    cnt_d = '0;
                end
            end
            StAcc: begin
                if (!abort && clk_en) begin
                    add   = 1'b1;
                    cnt_d = cnt_q + LOG2_WIN'(1);
                end
            end
            StDone: begin
                if (!abort) begin
                    load = 1'b1;
                    // Back-to-back: a sample arriving during DONE opens the next window.
                    if (mode_cont) begin
                        clr   = 1'b1;
                        add   = clk_en;
                        cnt_d = LOG2_WIN'(clk_en);
                    end
                end
            end
            default: ;
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        meas_ch_acc #(
            .DATA_W   (DATA_W),
            .LOG2_WIN (LOG2_WIN)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .clr        (clr),
            .add        (add),
            .load       (load),
            .dec_var    (dec_var[c*DATA_W +: DATA_W]),
            .err        (err[c*DATA_W +: DATA_W]),
            .mean_abs   (mean_abs[c*DATA_W +: DATA_W]),
            .avg_pow    (avg_pow[c*DATA_W +: DATA_W]),
            .acc_sq_err (acc_sq_err[c*DATA_W +: DATA_W])
`ifdef MEAS_PEAK_ERR_EN
            ,
            .peak_err   (peak_err[c*DATA_W +: DATA_W])
`endif
        );
    end

endmodule

// File: tb/tb_meas_window_acc.sv
// Randomised bench for meas_window_acc with a sample-list reference model
// and an expected-result scoreboard consumed on every done pulse.
`timescale 1ns/1ps
module tb_meas_window_acc;

    localparam int NUM_CH = 2;
    localparam int DW     = 18;
    localparam int LW     = 4;
    localparam int N      = 16;
    localparam int SMAX   = 131071;

    typedef struct packed {
        logic [NUM_CH*DW-1:0] ma;
        logic [NUM_CH*DW-1:0] ap;
        logic [NUM_CH*DW-1:0] se;
        logic [NUM_CH*DW-1:0] pk;
    } res_t;

    logic clk = 1'b0;
    logic reset, clk_en, start, abort, mode_cont;
    logic [NUM_CH*DW-1:0] dec_var, err, mean_abs, avg_pow, acc_sq_err;
    logic busy, done;
`ifdef MEAS_PEAK_ERR_EN
    logic [NUM_CH*DW-1:0] peak_err;
`endif

    always #5 clk = ~clk;

    meas_window_acc #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DW),
        .LOG2_WIN (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .start      (start),
        .abort      (abort),
        .mode_cont  (mode_cont),
        .dec_var    (dec_var),
        .err        (err),
        .mean_abs   (mean_abs),
        .avg_pow    (avg_pow),
        .acc_sq_err (acc_sq_err),
        .busy       (busy),
        .done       (done)
`ifdef MEAS_PEAK_ERR_EN
        ,
        .peak_err   (peak_err)
`endif
    );

    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_en   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int abs_ref(input int x);
        if (x < -SMAX) return SMAX;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int sq_ref(input int x);
        longint p;
        p = longint'(x) * longint'(x);
        p = p >> (DW - 1);
        return (p > SMAX) ? SMAX : int'(p);
    endfunction

    int   ph;              // 0 idle, 1 accumulating, 2 result cycle
    int   win_d[$];
    int   win_e[$];
    res_t exp_q[$];
    res_t m_out;
    res_t m_r;
    res_t mon_r;
    logic m_done;

    function automatic res_t expect_win();
        res_t r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            longint sa, sp, se;
            int pk;
            logic [DW-1:0] t;
            sa = 0; sp = 0; se = 0; pk = 0;
            for (int s = 0; s < N; s++) begin
                sa += abs_ref(win_d[s*NUM_CH + c]);
                sp += sq_ref(win_d[s*NUM_CH + c]);
                se += sq_ref(win_e[s*NUM_CH + c]);
                if (abs_ref(win_e[s*NUM_CH + c]) > pk) pk = abs_ref(win_e[s*NUM_CH + c]);
            end
            t = DW'(sa / N); r.ma[c*DW +: DW] = t;
            t = DW'(sp / N); r.ap[c*DW +: DW] = t;
            t = DW'(se / N); r.se[c*DW +: DW] = t;
            t = DW'(pk);     r.pk[c*DW +: DW] = t;
        end
        return r;
    endfunction

    task automatic take_sample();
        for (int c = 0; c < NUM_CH; c++) begin
            logic signed [DW-1:0] td, te;
            td = dec_var[c*DW +: DW];
            te = err[c*DW +: DW];
            win_d.push_back(int'(td));
            win_e.push_back(int'(te));
        end
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            ph = 0;
            m_out = '0;
            win_d.delete();
            win_e.delete();
        end else begin
            case (ph)
                0: if (start && !abort) begin
                    win_d.delete();
                    win_e.delete();
                    ph = 1;
                end
                1: if (abort) begin
                    ph = 0;
                end else if (clk_en) begin
                    take_sample();
                    if (win_d.size() == N*NUM_CH) ph = 2;
                end
                default: if (abort) begin
                    ph = 0;
                end else begin
                    m_r = expect_win();
                    exp_q.push_back(m_r);
                    m_out  = m_r;
                    m_done = 1'b1;
                    win_d.delete();
                    win_e.delete();
                    if (mode_cont) begin
                        ph = 1;
                        if (clk_en) take_sample();
                    end else begin
                        ph = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    task automatic cmp_res(input string tag, input res_t r);
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("%s mean_abs ch%0d", tag, c), mean_abs[c*DW +: DW], r.ma[c*DW +: DW]);
            check($sformatf("%s avg_pow ch%0d", tag, c), avg_pow[c*DW +: DW], r.ap[c*DW +: DW]);
            check($sformatf("%s acc_sq_err ch%0d", tag, c), acc_sq_err[c*DW +: DW],
                  r.se[c*DW +: DW]);
`ifdef MEAS_PEAK_ERR_EN
            check($sformatf("%s peak_err ch%0d", tag, c), peak_err[c*DW +: DW], r.pk[c*DW +: DW]);
`endif
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", busy, (ph != 0) ? 1 : 0);
            check("done", done, m_done);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard: done pulsed with no expected window");
                end else begin
                    mon_r = exp_q.pop_front();
                    cmp_res("window", mon_r);
                end
            end else begin
                cmp_res("held", m_out);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_val();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic set_ch(input int c, input int d, input int e);
        dec_var[c*DW +: DW] = d[DW-1:0];
        err[c*DW +: DW]     = e[DW-1:0];
    endtask

    // kind 0: err=65536; 1: dec alternates +/-98304; 2: err ch0 min, ch1 0;
    // 3: fully random; 4: small err with a -40000 peak on ch0 at sample 5
    task automatic drive_data(input int kind, input int k);
        for (int c = 0; c < NUM_CH; c++) begin
            int d, e;
            d = rand_val();
            e = rand_val();
            case (kind)
                0: e = 65536;
                1: d = (k % 2 == 0) ? 98304 : -98304;
                2: e = (c == 0) ? -131072 : 0;
                4: begin
                    e = int'($urandom_range(0, 60000)) - 30000;
                    if (k == 5 && c == 0) e = -40000;
                end
                default: ;
            endcase
            set_ch(c, d, e);
        end
    endtask

    task automatic one_window(input int kind, input int en_pct, output int lat);
        int k;
        lat = -1;
        k = 0;
        mode_cont = 1'b0;
        clk_en = 1'b1;
        start = 1'b1;
        drive_data(kind, 0);
        tick();
        start = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            clk_en = ($urandom_range(0, 99) < en_pct);
            drive_data(kind, k);
            if (clk_en) k++;
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL window kind %0d: done never seen", kind);
        end
        clk_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    int lat;
    int n_done;
    logic [NUM_CH*DW-1:0] sv_ma, sv_ap, sv_se;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; clk_en = 1'b0; start = 1'b0; abort = 1'b0; mode_cont = 1'b0;
        dec_var = '0; err = '0;
        tick();
        mon_en = 1'b1;
        tick();
        check("reset mean_abs", mean_abs, 0);
        check("reset busy", busy, 0);
        reset = 1'b0;
        tick();

        // Constant err: mean err^2 = 32768, done 17 clocks after start
        one_window(0, 100, lat);
        check("s1 latency", lat, 17);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("s1 acc_sq_err ch%0d", c), acc_sq_err[c*DW +: DW], 32768);
        repeat (3) tick();

        one_window(1, 100, lat);
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("alt mean_abs ch%0d", c), mean_abs[c*DW +: DW], 98304);
            check($sformatf("alt avg_pow ch%0d", c), avg_pow[c*DW +: DW], 73728);
        end

        one_window(2, 100, lat);
        check("sat acc_sq_err ch0", acc_sq_err[0 +: DW], 131071);
        check("sat acc_sq_err ch1", acc_sq_err[DW +: DW], 0);

        one_window(4, 100, lat);
`ifdef MEAS_PEAK_ERR_EN
        check("peak_err ch0", peak_err[0 +: DW], 40000);
`endif

        // Sparse clk_en windows
        for (int w = 0; w < 3; w++) one_window(3, 45, lat);

        // Continuous back-to-back windows, clk_en every clock
        mode_cont = 1'b1;
        clk_en = 1'b1;
        start = 1'b1;
        drive_data(3, 0);
        tick();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 67; i++) begin
            drive_data(3, 0);
            tick();
            if (done) n_done++;
        end
        mode_cont = 1'b0;
        wait_idle("cont stop idle");
        check("cont done count", (n_done >= 3) ? 1 : 0, 1);
        clk_en = 1'b0;
        tick();

        // Abort on the 8th sample with start in the same cycle
        sv_ma = mean_abs; sv_ap = avg_pow; sv_se = acc_sq_err;
        clk_en = 1'b1;
        start = 1'b1;
        drive_data(3, 0);
        tick();
        start = 1'b0;
        repeat (7) begin
            drive_data(3, 0);
            tick();
        end
        abort = 1'b1;
        start = 1'b1;
        drive_data(3, 0);
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        tick();
        check("abort start ignored", busy, 0);
        check("abort hold mean_abs", mean_abs, sv_ma);
        check("abort hold avg_pow", avg_pow, sv_ap);
        check("abort hold acc_sq_err", acc_sq_err, sv_se);

        // Reset mid-window
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) begin
            drive_data(3, 0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset mean_abs", mean_abs, 0);
        check("midreset avg_pow", avg_pow, 0);
        check("midreset acc_sq_err", acc_sq_err, 0);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        clk_en = 1'b0;
        tick();

        // Random control traffic, including aborts in any state
        for (int i = 0; i < 400; i++) begin
            start  = ($urandom_range(0, 9) == 0);
            abort  = ($urandom_range(0, 49) == 0);
            clk_en = ($urandom_range(0, 99) < 70);
            if (i % 50 == 0) mode_cont = 1'($urandom_range(0, 1));
            drive_data(3, 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        mode_cont = 1'b0;
        clk_en = 1'b1;
        wait_idle("final idle");
        clk_en = 1'b0;
        repeat (3) tick();
        check("scoreboard empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
